// File: rtl/des_range_scheduler.sv
// Splits a programmed DES key range into fixed-size chunks on a valid/ready stream,
// and buffers match keys reported by the cores in a small FWFT result FIFO.
module des_range_scheduler #(
    parameter int KEY_W      = 56,
    parameter int CHUNK_LOG2 = 8,
    parameter int RES_DEPTH  = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         start,
    input  logic                         abort,
    input  logic [KEY_W-1:0]             range_start,
    input  logic [KEY_W-1:0]             range_end,
    output logic                         chunk_valid,
    input  logic                         chunk_ready,
    output logic [KEY_W-1:0]             chunk_base,
    output logic [CHUNK_LOG2:0]          chunk_len,
    input  logic                         match_valid,
    input  logic [KEY_W-1:0]             match_key,
    input  logic                         res_pop,
    output logic                         res_valid,
    output logic [KEY_W-1:0]             res_key,
    output logic [$clog2(RES_DEPTH):0]   res_count,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [31:0]                  chunks_issued
);

    localparam int AW = $clog2(RES_DEPTH);
    localparam logic [KEY_W:0] CHUNK_KEYS = {{KEY_W{1'b0}}, 1'b1} << CHUNK_LOG2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  cursor_q, cursor_d;
    logic [KEY_W-1:0]  end_q, end_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       chunks_q, chunks_d;

    logic [KEY_W-1:0]  mem_q [RES_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       count_q, count_d;

    logic [KEY_W:0]    rem;
    logic              handshake;
    logic              start_ok;
    logic              fifo_full;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;

    // Remaining keys are computed one bit wider so a range ending at the top key cannot wrap.
    assign rem       = {1'b0, end_q} - {1'b0, cursor_q} + {{KEY_W{1'b0}}, 1'b1};
    assign handshake = (state_q == S_ISSUE) && chunk_ready;
    assign start_ok  = !abort && (state_q == S_IDLE) && start;

    assign fifo_full = (count_q == (AW+1)'(RES_DEPTH));
    assign pop_ok    = res_pop && (count_q != '0);
    assign push_ok   = match_valid && (!fifo_full || pop_ok);
    assign drop      = match_valid && fifo_full && !pop_ok;

    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        end_d      = end_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        chunks_d   = chunks_q;

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        chunks_d = '0;
                        if (range_start <= range_end) begin
                            cursor_d = range_start;
                            end_d    = range_end;
                            done_d   = 1'b0;
                            state_d  = S_ISSUE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (chunk_ready) begin
                        if (rem <= CHUNK_KEYS) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cursor_d = cursor_q + CHUNK_KEYS[KEY_W-1:0];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // The arbiter saw the handshake even if abort arrives with it, so it is counted.
        if (handshake && (chunks_q != 32'hFFFF_FFFF)) begin
            chunks_d = chunks_q + 32'd1;
        end

        if (start_ok) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            cursor_q   <= '0;
            end_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            chunks_q   <= '0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            end_q      <= end_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            chunks_q   <= chunks_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= match_key;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign busy          = (state_q == S_ISSUE);
    assign chunk_valid   = busy;
    assign chunk_base    = busy ? cursor_q : '0;
    assign chunk_len     = !busy ? '0 :
                           (rem >= CHUNK_KEYS) ? CHUNK_KEYS[CHUNK_LOG2:0] : rem[CHUNK_LOG2:0];
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign chunks_issued = chunks_q;
    assign res_valid     = (count_q != '0);
    assign res_key       = res_valid ? mem_q[rd_q] : '0;
    assign res_count     = count_q;

endmodule

// File: tb/tb_des_range_scheduler.sv
// Bench for des_range_scheduler: range vectors from a table with a chunk scoreboard,
// plus hand-written FIFO, abort and reset sequences.
module tb_des_range_scheduler;

    localparam int KEY_W = 56;
    localparam int CL2   = 8;
    localparam int DEPTH = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              start, abort;
    logic [KEY_W-1:0]  range_start, range_end;
    logic              chunk_valid, chunk_ready;
    logic [KEY_W-1:0]  chunk_base;
    logic [CL2:0]      chunk_len;
    logic              match_valid;
    logic [KEY_W-1:0]  match_key;
    logic              res_pop, res_valid;
    logic [KEY_W-1:0]  res_key;
    logic [2:0]        res_count;
    logic              busy, done, overflow;
    logic [31:0]       chunks_issued;

    des_range_scheduler #(.KEY_W(KEY_W), .CHUNK_LOG2(CL2), .RES_DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
        .range_start(range_start), .range_end(range_end),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
        .chunk_base(chunk_base), .chunk_len(chunk_len),
        .match_valid(match_valid), .match_key(match_key),
        .res_pop(res_pop), .res_valid(res_valid), .res_key(res_key), .res_count(res_count),
        .busy(busy), .done(done), .overflow(overflow), .chunks_issued(chunks_issued)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [KEY_W-1:0] rs;
        logic [KEY_W-1:0] re;
        int               n_chunks;
        logic [KEY_W-1:0] last_base;
        logic [CL2:0]     last_len;
        int               mode;     // 0: ready always, 1: toggling, 2: random
    } vec_t;

    typedef struct {
        logic [KEY_W-1:0] base;
        logic [CL2:0]     len;
    } chunk_t;

    int n_cmp = 0;
    int n_err = 0;

    chunk_t           exp_q[$];
    logic [KEY_W-1:0] fq[$];
    logic             exp_ovf;
    logic [KEY_W-1:0] last_base;
    logic [CL2:0]     last_len;
    logic             stall_q = 1'b0;
    logic [KEY_W-1:0] stall_base;
    logic [CL2:0]     stall_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Chunk monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (stall_q && chunk_valid) begin
                check("stall_base", chunk_base, stall_base);
                check("stall_len", chunk_len, stall_len);
            end
            if (chunk_valid && chunk_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_chunk: got base %0h len %0d expected none", chunk_base, chunk_len);
                end else begin
                    chunk_t e;
                    e = exp_q.pop_front();
                    check("chunk_base", chunk_base, e.base);
                    check("chunk_len", chunk_len, e.len);
                    last_base = chunk_base;
                    last_len  = chunk_len;
                end
            end
            stall_q    = chunk_valid && !chunk_ready;
            stall_base = chunk_base;
            stall_len  = chunk_len;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_chunks(input logic [KEY_W-1:0] rs, input logic [KEY_W-1:0] re);
        logic [KEY_W:0] b;
        logic [KEY_W:0] r;
        chunk_t c;
        if (rs <= re) begin
            b = {1'b0, rs};
            for (int k = 0; k < 1000; k++) begin
                r = {1'b0, re} - b + 1;
                c.base = b[KEY_W-1:0];
                c.len  = (r >= 257'(256)) ? 9'd256 : r[CL2:0];
                exp_q.push_back(c);
                if (r <= 256) break;
                b = b + 256;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cycles;
        string nm;
        nm = $sformatf("v%0d", idx);
        model_chunks(v.rs, v.re);
        range_start = v.rs;
        range_end   = v.re;
        chunk_ready = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        if (v.n_chunks == 0) begin
            check({nm, "_inv_done"}, done, 1);
            check({nm, "_inv_busy"}, busy, 0);
            check({nm, "_inv_count"}, chunks_issued, 0);
            for (int k = 0; k < 3; k++) begin
                chunk_ready = 1'b1;
                tick();
                check({nm, "_inv_valid"}, chunk_valid, 0);
            end
            chunk_ready = 1'b0;
        end else begin
            check({nm, "_start_busy"}, busy, 1);
            check({nm, "_start_valid"}, chunk_valid, 1);
            check({nm, "_start_base"}, chunk_base, v.rs);
            check({nm, "_start_cnt"}, chunks_issued, 0);
            cycles = 0;
            while (busy && cycles < 64) begin
                case (v.mode)
                    0:       chunk_ready = 1'b1;
                    1:       chunk_ready = cycles[0];
                    default: chunk_ready = 1'($urandom_range(0, 1));
                endcase
                tick();
                cycles++;
            end
            chunk_ready = 1'b0;
            check({nm, "_end_busy"}, busy, 0);
            check({nm, "_end_valid"}, chunk_valid, 0);
            check({nm, "_end_done"}, done, 1);
            check({nm, "_end_count"}, chunks_issued, 32'(v.n_chunks));
            check({nm, "_sb_empty"}, exp_q.size(), 0);
            check({nm, "_last_base"}, last_base, v.last_base);
            check({nm, "_last_len"}, last_len, v.last_len);
            if (v.mode == 0) begin
                check({nm, "_b2b_cycles"}, cycles, v.n_chunks);
            end
        end
    endtask

    task automatic push_match(input logic [KEY_W-1:0] k);
        match_valid = 1'b1;
        match_key   = k;
        if (fq.size() < DEPTH) fq.push_back(k);
        else exp_ovf = 1'b1;
        tick();
        match_valid = 1'b0;
    endtask

    task automatic pop_check(input string nm);
        logic [KEY_W-1:0] e;
        if (fq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got pop with empty model expected non-empty", nm);
        end else begin
            e = fq.pop_front();
            check(nm, res_key, e);
        end
        res_pop = 1'b1;
        tick();
        res_pop = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_cv"}, chunk_valid, 0);
        check({nm, "_cb"}, chunk_base, 0);
        check({nm, "_cl"}, chunk_len, 0);
        check({nm, "_rv"}, res_valid, 0);
        check({nm, "_rk"}, res_key, 0);
        check({nm, "_rc"}, res_count, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_ovf"}, overflow, 0);
        check({nm, "_cnt"}, chunks_issued, 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{rs: 56'h0,              re: 56'h3FF,            n_chunks: 4, last_base: 56'h300,            last_len: 9'd256, mode: 0};
        vecs[1] = '{rs: 56'h10,             re: 56'h114,            n_chunks: 2, last_base: 56'h110,            last_len: 9'd5,   mode: 1};
        vecs[2] = '{rs: 56'hFFFFFFFFFFFF80, re: 56'hFFFFFFFFFFFFFF, n_chunks: 1, last_base: 56'hFFFFFFFFFFFF80, last_len: 9'd128, mode: 0};
        vecs[3] = '{rs: 56'h20,             re: 56'h1F,             n_chunks: 0, last_base: 56'h0,              last_len: 9'd0,   mode: 0};
        vecs[4] = '{rs: 56'h5,              re: 56'h5,              n_chunks: 1, last_base: 56'h5,              last_len: 9'd1,   mode: 2};
        vecs[5] = '{rs: 56'h0,              re: 56'hFF,             n_chunks: 1, last_base: 56'h0,              last_len: 9'd256, mode: 1};
        vecs[6] = '{rs: 56'h1000,           re: 56'h1300,           n_chunks: 4, last_base: 56'h1300,           last_len: 9'd1,   mode: 2};

        ARESET = 1'b1; start = 1'b0; abort = 1'b0;
        range_start = '0; range_end = '0; chunk_ready = 1'b0;
        match_valid = 1'b0; match_key = '0; res_pop = 1'b0;
        exp_ovf = 1'b0; last_base = '0; last_len = '0;
        repeat (3) tick();
        ARESET = 1'b0;
        tick();
        check_all_zero("reset");

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Result FIFO: overflow, ordering, empty pop, simultaneous push/pop when full
        push_match(56'hA1);
        check("fifo_lat_valid", res_valid, 1);
        check("fifo_lat_key", res_key, 56'hA1);
        check("fifo_lat_count", res_count, 1);
        for (int k = 2; k <= 5; k++) push_match(56'hA0 + 56'(k));
        check("fifo_full_count", res_count, 4);
        check("fifo_ovf", overflow, exp_ovf);
        for (int k = 0; k < 4; k++) pop_check($sformatf("fifo_pop%0d", k));
        check("fifo_drained_valid", res_valid, 0);
        check("fifo_drained_count", res_count, 0);
        res_pop = 1'b1;
        tick();
        res_pop = 1'b0;
        check("fifo_empty_pop_count", res_count, 0);
        check("fifo_ovf_kept", overflow, 1);

        range_start = 56'h20; range_end = 56'h1F; start = 1'b1;
        tick();
        start = 1'b0;
        exp_ovf = 1'b0;
        check("start_clears_ovf", overflow, exp_ovf);

        for (int k = 1; k <= 4; k++) push_match(56'hB0 + 56'(k));
        check("refill_count", res_count, 4);
        check("pushpop_head", res_key, fq[0]);
        void'(fq.pop_front());
        fq.push_back(56'hB5);
        match_valid = 1'b1; match_key = 56'hB5; res_pop = 1'b1;
        tick();
        match_valid = 1'b0; res_pop = 1'b0;
        check("pushpop_count", res_count, 4);
        check("pushpop_ovf", overflow, exp_ovf);
        for (int k = 0; k < 4; k++) pop_check($sformatf("pushpop_drain%0d", k));
        check("pushpop_empty", res_valid, 0);

        // Abort while stalled, then abort+start in the same cycle, then a normal run
        range_start = 56'h0; range_end = 56'h3FF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("stall_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", chunk_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_valid", chunk_valid, 0);
        run_vec(vecs[0], 10);

        // Reset in the middle of a stalled search with FIFO contents present
        push_match(56'hC3);
        range_start = 56'h0; range_end = 56'h3FF; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_fifo", res_count, 1);
        ARESET = 1'b1;
        tick();
        check_all_zero("midrst");
        ARESET = 1'b0;
        fq.delete();
        tick();
        check_all_zero("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
